csr_fifo_register: RTL and testbench
====================================

# csr_fifo_register

Parametrised CSR-mapped FIFO port for the core's CSR space: a data CSR plus a status CSR front a transmit FIFO (CSR writes → system) and a receive FIFO (system → CSR reads). It lets a peripheral stream words to or from the core without the core polling on every word. It adds buffering, flow control, sticky error flags and a threshold interrupt. It sits on the shared CSR read/write bus alongside the other CSR blocks.

## Interface
- ADDRESS, 12'h000, data CSR address (write = TX push, read = RX pop)
- STATUS_ADDRESS, 12'h001, status/control CSR address
- WIDTH, 32, data word width, 1..32; CSR data zero-extended/truncated to WIDTH
- TX_DEPTH, 4, TX FIFO entries, power of two, 2..128
- RX_DEPTH, 4, RX FIFO entries, power of two, 2..128
- RX_THRESHOLD, 1, irq asserts when rxCount ≥ this (1..RX_DEPTH)
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- csrWriteEnable  input  1  CSR write strobe
- csrReadEnable  input  1  CSR read strobe
- csrWriteAddress  input  12  CSR write address
- csrReadAddress  input  12  CSR read address
- csrWriteData  input  32  CSR write data
- csrReadData  output  32  read data; 0 when not selected
- csrRequestOutput  output  1  high when a read hits ADDRESS or STATUS_ADDRESS
- txData  output  WIDTH  TX FIFO head
- txValid  output  1  TX FIFO non-empty
- txReady  input  1  consumer accepts head on txValid && txReady
- rxData  input  WIDTH  incoming word
- rxValid  input  1  incoming word valid
- rxReady  output  1  RX FIFO not full
- irq  output  1  level interrupt: (rxCount ≥ RX_THRESHOLD && rxIrqEnable) || (txEmpty && txIrqEnable)

## Operation
- Reset (rst low, asynchronous): both FIFOs empty, pointers 0, sticky flags 0, enables 0. Outputs: txValid 0, txData 0, rxReady 1, irq 0, csrReadData 0, csrRequestOutput 0.
- TX push: csrWriteEnable && csrWriteAddress==ADDRESS. Pushes csrWriteData[WIDTH-1:0] if TX not full at the start of the cycle. A push while full is dropped and sets txOverflow. A same-cycle pop does not make room.
- TX pop: txValid && txReady. Advances the TX read pointer.
- RX push: rxValid && rxReady. rxReady = !rxFull, so overflow is impossible.
- RX pop: csrReadEnable && csrReadAddress==ADDRESS. csrReadData = zero-extended RX head, combinationally in the same cycle; the pointer advances at the clock edge. When RX is empty, csrReadData = 0, no pointer change, and rxUnderflow is set.
- Status read (STATUS_ADDRESS): [0] txFull, [1] txEmpty, [2] rxFull, [3] rxEmpty, [4] txOverflow, [5] rxUnderflow, [6] txIrqEnable, [7] rxIrqEnable, [15:8] txCount, [23:16] rxCount, [31:24] 0. A status read has no side effects.
- Status write: bit4/bit5 write-1-to-clear the sticky flags. A flag set and cleared in the same cycle ends set. Bits 6/7 are written directly. Other bits are ignored.
- Counts are clog2(DEPTH)+1 bits wide, zero-extended into 8-bit fields. Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- Simultaneous push+pop on a non-empty, non-full FIFO: count unchanged, both pointers advance.
- A read and a write to different addresses in the same cycle are both honoured.

## Timing
- TX: CSR write at edge N → txValid high and txData valid after edge N. No fall-through.
- RX: handshake at edge M → data poppable and counted in the status from cycle M+1.
- csrReadData and csrRequestOutput are combinational from the address, strobe and FIFO state, with zero latency.
- irq is derived from registered state, so it updates the cycle after the causing edge.
- Reset mid-transfer discards all buffered data immediately. txValid drops asynchronously.

## Test plan
- Reset: hold rst low mid-stream → txValid 0, rxReady 1, irq 0, status read = 32'h0000_000A (both empty).
- TX fill (TX_DEPTH=4): 5 CSR writes 0x11..0x55 with txReady 0 → status txCount 4, txFull 1, txOverflow 1. Then txReady 1 → txData 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then txValid 0.
- RX order/wrap: push 0xA0..0xA5 with interleaved CSR reads keeping count ≤ 4 → reads return 0xA0..0xA5 in order. rxReady is 0 only while count = 4.
- Underflow/W1C: CSR read of ADDRESS with RX empty → csrReadData 0, status bit5 1. Write status 0x20 → bit5 0. Write 0x20 in the same cycle as a new underflow → bit5 stays 1.
- Concurrency: TX holds 2 entries; CSR write + txReady in the same cycle → txCount stays 2. With TX full, write + pop in the same cycle → write dropped, txOverflow set, count 3.
- irq: RX_THRESHOLD=2, rxIrqEnable=1 → irq 0 after 1 RX push, 1 the cycle after the 2nd push, 0 the cycle after one CSR pop.

Source files
------------

// File: rtl/csr_fifo_register.sv
// CSR-mapped FIFO port: a data CSR pushes to a TX FIFO and pops from an RX FIFO,
// and a status CSR exposes levels, sticky error flags and the interrupt enables.
module csr_fifo_register #(
    parameter logic [11:0] ADDRESS        = 12'h000,
    parameter logic [11:0] STATUS_ADDRESS = 12'h001,
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TX_DEPTH       = 4,
    parameter int unsigned RX_DEPTH       = 4,
    parameter int unsigned RX_THRESHOLD   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             csrWriteEnable,
    input  logic             csrReadEnable,
    input  logic [11:0]      csrWriteAddress,
    input  logic [11:0]      csrReadAddress,
    input  logic [31:0]      csrWriteData,
    output logic [31:0]      csrReadData,
    output logic             csrRequestOutput,
    output logic [WIDTH-1:0] txData,
    output logic             txValid,
    input  logic             txReady,
    input  logic [WIDTH-1:0] rxData,
    input  logic             rxValid,
    output logic             rxReady,
    output logic             irq
);

    localparam int unsigned TAW = $clog2(TX_DEPTH);
    localparam int unsigned TCW = TAW + 1;
    localparam int unsigned RAW = $clog2(RX_DEPTH);
    localparam int unsigned RCW = RAW + 1;
    localparam logic [TCW-1:0] TX_FULL_CNT = TCW'(TX_DEPTH);
    localparam logic [RCW-1:0] RX_FULL_CNT = RCW'(RX_DEPTH);
    localparam logic [RCW-1:0] RX_IRQ_CNT  = RCW'(RX_THRESHOLD);

    logic [WIDTH-1:0] r_tx_mem [TX_DEPTH];
    logic [TAW-1:0]   r_tx_wptr;
    logic [TAW-1:0]   r_tx_rptr;
    logic [TCW-1:0]   r_tx_count;
    logic [WIDTH-1:0] r_rx_mem [RX_DEPTH];
    logic [RAW-1:0]   r_rx_wptr;
    logic [RAW-1:0]   r_rx_rptr;
    logic [RCW-1:0]   r_rx_count;
    logic             r_tx_overflow;
    logic             r_rx_underflow;
    logic             r_tx_irq_en;
    logic             r_rx_irq_en;

    logic             w_tx_full;
    logic             w_tx_empty;
    logic             w_tx_push_req;
    logic             w_tx_push;
    logic             w_tx_pop;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic             w_rx_pop_req;
    logic             w_rx_pop;
    logic             w_rx_push;
    logic             w_stat_wr;
    logic             w_read_data;
    logic             w_read_stat;
    logic [31:0]      w_rx_head;
    logic [31:0]      w_status;

    always_comb begin
        w_tx_full     = (r_tx_count == TX_FULL_CNT);
        w_tx_empty    = (r_tx_count == '0);
        w_rx_full     = (r_rx_count == RX_FULL_CNT);
        w_rx_empty    = (r_rx_count == '0);
        w_tx_push_req = csrWriteEnable && (csrWriteAddress == ADDRESS);
        w_stat_wr     = csrWriteEnable && (csrWriteAddress == STATUS_ADDRESS);
        w_read_data   = csrReadEnable && (csrReadAddress == ADDRESS);
        w_read_stat   = csrReadEnable && (csrReadAddress == STATUS_ADDRESS);
        // Fullness is judged before this cycle's pop, so a pop never makes room for a push
        w_tx_push     = w_tx_push_req && !w_tx_full;
        w_tx_pop      = !w_tx_empty && txReady;
        w_rx_pop_req  = w_read_data;
        w_rx_pop      = w_rx_pop_req && !w_rx_empty;
        w_rx_push     = rxValid && !w_rx_full;
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= csrWriteData[WIDTH-1:0];
        end
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= rxData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wptr <= r_tx_wptr + 1'b1;
            end
            if (w_tx_pop) begin
                r_tx_rptr <= r_tx_rptr + 1'b1;
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + 1'b1;
                2'b01:   r_tx_count <= r_tx_count - 1'b1;
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wptr <= r_rx_wptr + 1'b1;
            end
            if (w_rx_pop) begin
                r_rx_rptr <= r_rx_rptr + 1'b1;
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + 1'b1;
                2'b01:   r_rx_count <= r_rx_count - 1'b1;
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    // Set wins over write-1-to-clear when both land on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_overflow  <= 1'b0;
            r_rx_underflow <= 1'b0;
            r_tx_irq_en    <= 1'b0;
            r_rx_irq_en    <= 1'b0;
        end else begin
            r_tx_overflow  <= (w_tx_push_req && w_tx_full) ||
                              (r_tx_overflow && !(w_stat_wr && csrWriteData[4]));
            r_rx_underflow <= (w_rx_pop_req && w_rx_empty) ||
                              (r_rx_underflow && !(w_stat_wr && csrWriteData[5]));
            if (w_stat_wr) begin
                r_tx_irq_en <= csrWriteData[6];
                r_rx_irq_en <= csrWriteData[7];
            end
        end
    end

    always_comb begin
        w_rx_head = '0;
        if (!w_rx_empty) begin
            w_rx_head[WIDTH-1:0] = r_rx_mem[r_rx_rptr];
        end
        w_status            = '0;
        w_status[0]         = w_tx_full;
        w_status[1]         = w_tx_empty;
        w_status[2]         = w_rx_full;
        w_status[3]         = w_rx_empty;
        w_status[4]         = r_tx_overflow;
        w_status[5]         = r_rx_underflow;
        w_status[6]         = r_tx_irq_en;
        w_status[7]         = r_rx_irq_en;
        w_status[8 +: TCW]  = r_tx_count;
        w_status[16 +: RCW] = r_rx_count;
    end

    always_comb begin
        csrRequestOutput = w_read_data || w_read_stat;
        if (w_read_data) begin
            csrReadData = w_rx_head;
        end else if (w_read_stat) begin
            csrReadData = w_status;
        end else begin
            csrReadData = '0;
        end
        txValid = !w_tx_empty;
        txData  = w_tx_empty ? '0 : r_tx_mem[r_tx_rptr];
        rxReady = !w_rx_full;
        irq     = ((r_rx_count >= RX_IRQ_CNT) && r_rx_irq_en) || (w_tx_empty && r_tx_irq_en);
    end

endmodule

// File: tb/tb_csr_fifo_register.sv
// Bench for csr_fifo_register: queue-based model checked every cycle, plus
// directed scenarios with hand-computed expected values.
module tb_csr_fifo_register;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        csrWriteEnable = 1'b0;
    logic        csrReadEnable = 1'b0;
    logic [11:0] csrWriteAddress = '0;
    logic [11:0] csrReadAddress = '0;
    logic [31:0] csrWriteData = '0;
    logic [31:0] csrReadData;
    logic        csrRequestOutput;
    logic [31:0] txData;
    logic        txValid;
    logic        txReady = 1'b0;
    logic [31:0] rxData = '0;
    logic        rxValid = 1'b0;
    logic        rxReady;
    logic        irq;

    int checks = 0;
    int errors = 0;

    csr_fifo_register #(
        .ADDRESS        (12'h000),
        .STATUS_ADDRESS (12'h001),
        .WIDTH          (32),
        .TX_DEPTH       (4),
        .RX_DEPTH       (4),
        .RX_THRESHOLD   (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .csrWriteEnable   (csrWriteEnable),
        .csrReadEnable    (csrReadEnable),
        .csrWriteAddress  (csrWriteAddress),
        .csrReadAddress   (csrReadAddress),
        .csrWriteData     (csrWriteData),
        .csrReadData      (csrReadData),
        .csrRequestOutput (csrRequestOutput),
        .txData           (txData),
        .txValid          (txValid),
        .txReady          (txReady),
        .rxData           (rxData),
        .rxValid          (rxValid),
        .rxReady          (rxReady),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    // Reference model: plain queues and flags
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic m_ovf = 1'b0;
    logic m_unf = 1'b0;
    logic m_txen = 1'b0;
    logic m_rxen = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_q.delete();
            rx_q.delete();
            m_ovf  <= 1'b0;
            m_unf  <= 1'b0;
            m_txen <= 1'b0;
            m_rxen <= 1'b0;
        end else begin
            bit tx_full0, tx_has0, rx_full0, rx_has0, push_req, pop_req, stat_wr;
            tx_full0 = (tx_q.size() == 4);
            tx_has0  = (tx_q.size() > 0);
            rx_full0 = (rx_q.size() == 4);
            rx_has0  = (rx_q.size() > 0);
            push_req = csrWriteEnable && csrWriteAddress == 12'h000;
            pop_req  = csrReadEnable && csrReadAddress == 12'h000;
            stat_wr  = csrWriteEnable && csrWriteAddress == 12'h001;
            if (tx_has0 && txReady) void'(tx_q.pop_front());
            if (push_req && !tx_full0) tx_q.push_back(csrWriteData);
            if (pop_req && rx_has0) void'(rx_q.pop_front());
            if (rxValid && !rx_full0) rx_q.push_back(rxData);
            m_ovf <= (push_req && tx_full0) || (m_ovf && !(stat_wr && csrWriteData[4]));
            m_unf <= (pop_req && !rx_has0) || (m_unf && !(stat_wr && csrWriteData[5]));
            if (stat_wr) begin
                m_txen <= csrWriteData[6];
                m_rxen <= csrWriteData[7];
            end
        end
    end

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        s[0] = (tx_q.size() == 4);
        s[1] = (tx_q.size() == 0);
        s[2] = (rx_q.size() == 4);
        s[3] = (rx_q.size() == 0);
        s[4] = m_ovf;
        s[5] = m_unf;
        s[6] = m_txen;
        s[7] = m_rxen;
        s[15:8]  = 8'(tx_q.size());
        s[23:16] = 8'(rx_q.size());
        return s;
    endfunction

    function automatic logic [31:0] model_read();
        if (csrReadEnable && csrReadAddress == 12'h000)
            return (rx_q.size() > 0) ? rx_q[0] : 32'h0;
        if (csrReadEnable && csrReadAddress == 12'h001)
            return model_status();
        return 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_txValid", 32'(txValid), 32'(tx_q.size() > 0));
        chk("m_txData", txData, (tx_q.size() > 0) ? tx_q[0] : 32'h0);
        chk("m_rxReady", 32'(rxReady), 32'(rx_q.size() < 4));
        chk("m_irq", 32'(irq), 32'((rx_q.size() >= 2 && m_rxen) || (tx_q.size() == 0 && m_txen)));
        chk("m_csrReq", 32'(csrRequestOutput),
            32'(csrReadEnable && (csrReadAddress == 12'h000 || csrReadAddress == 12'h001)));
        chk("m_csrReadData", csrReadData, model_read());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        csrWriteEnable  = 1'b1;
        csrWriteAddress = addr;
        csrWriteData    = data;
        tick();
        csrWriteEnable  = 1'b0;
    endtask

    task automatic check_status(input string name, input logic [31:0] exp);
        csrReadEnable  = 1'b1;
        csrReadAddress = 12'h001;
        #1;
        chk(name, csrReadData, exp);
        csrReadEnable  = 1'b0;
    endtask

    task automatic rx_pop(input string name, input logic [31:0] exp);
        csrReadEnable  = 1'b1;
        csrReadAddress = 12'h000;
        #1;
        chk(name, csrReadData, exp);
        tick();
        csrReadEnable  = 1'b0;
    endtask

    logic [31:0] fill_vals [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_txValid", 32'(txValid), 32'h0);
        chk("rst_rxReady", 32'(rxReady), 32'h1);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_csrReadData", csrReadData, 32'h0);
        chk("rst_csrReq", 32'(csrRequestOutput), 32'h0);
        check_status("rst_status", 32'h0000_000A);
        rst = 1'b1;
        tick();

        // TX fill with the consumer stalled, fifth write overflows
        for (int i = 0; i < 5; i++) csr_write(12'h000, fill_vals[i]);
        check_status("txfill_status", 32'h0000_0419);
        txReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("tx_drain_valid", 32'(txValid), 32'h1);
            chk("tx_drain_data", txData, fill_vals[i]);
            tick();
        end
        chk("tx_drained", 32'(txValid), 32'h0);
        txReady = 1'b0;
        csr_write(12'h001, 32'h10);
        check_status("ovf_clear", 32'h0000_000A);

        // RX ordering across pointer wrap
        rxValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rxData = 32'hA0 + 32'(i);
            tick();
        end
        rxValid = 1'b0;
        chk("rx_full_ready", 32'(rxReady), 32'h0);
        check_status("rx_full_status", 32'h0004_0006);
        rx_pop("rx_pop_a0", 32'hA0);
        chk("rx_ready_after_pop", 32'(rxReady), 32'h1);
        rxValid = 1'b1; rxData = 32'hA4; tick(); rxValid = 1'b0;
        chk("rx_full_again", 32'(rxReady), 32'h0);
        rx_pop("rx_pop_a1", 32'hA1);
        rxValid = 1'b1; rxData = 32'hA5; tick(); rxValid = 1'b0;
        for (int i = 2; i < 6; i++) rx_pop("rx_pop_seq", 32'hA0 + 32'(i));
        check_status("rx_empty_status", 32'h0000_000A);

        // Underflow and write-1-to-clear, including same-cycle set/clear
        rx_pop("unf_read", 32'h0);
        check_status("unf_status", 32'h0000_002A);
        csr_write(12'h001, 32'h20);
        check_status("unf_clear", 32'h0000_000A);
        csrReadEnable = 1'b1; csrReadAddress = 12'h000;
        csrWriteEnable = 1'b1; csrWriteAddress = 12'h001; csrWriteData = 32'h20;
        tick();
        csrReadEnable = 1'b0; csrWriteEnable = 1'b0;
        check_status("unf_set_wins", 32'h0000_002A);
        csr_write(12'h001, 32'h20);

        // Concurrent push and pop on TX
        csr_write(12'h000, 32'h61);
        csr_write(12'h000, 32'h62);
        txReady = 1'b1;
        csr_write(12'h000, 32'h63);
        txReady = 1'b0;
        check_status("conc_count2", 32'h0000_0208);
        chk("conc_head", txData, 32'h62);
        csr_write(12'h000, 32'h64);
        csr_write(12'h000, 32'h65);
        txReady = 1'b1;
        csr_write(12'h000, 32'h66);
        txReady = 1'b0;
        check_status("conc_full_drop", 32'h0000_0318);
        chk("conc_full_head", txData, 32'h63);
        txReady = 1'b1;
        repeat (3) tick();
        txReady = 1'b0;
        chk("conc_drained", 32'(txValid), 32'h0);
        csr_write(12'h001, 32'h10);

        // Threshold interrupt (threshold 2)
        csr_write(12'h001, 32'h80);
        chk("irq_none", 32'(irq), 32'h0);
        rxValid = 1'b1; rxData = 32'hB0; tick(); rxValid = 1'b0;
        chk("irq_one", 32'(irq), 32'h0);
        rxValid = 1'b1; rxData = 32'hB1; tick(); rxValid = 1'b0;
        chk("irq_two", 32'(irq), 32'h1);
        rx_pop("irq_pop", 32'hB0);
        chk("irq_after_pop", 32'(irq), 32'h0);
        csr_write(12'h001, 32'h40);
        chk("irq_txempty", 32'(irq), 32'h1);
        check_status("irq_status", 32'h0001_0042);
        rx_pop("irq_pop2", 32'hB1);

        // Asynchronous reset with data buffered on both sides
        csr_write(12'h001, 32'hC0);
        csr_write(12'h000, 32'h71);
        rxValid = 1'b1; rxData = 32'hC0; tick(); rxValid = 1'b0;
        chk("pre_rst_txValid", 32'(txValid), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_txValid", 32'(txValid), 32'h0);
        chk("mid_rst_txData", txData, 32'h0);
        chk("mid_rst_rxReady", 32'(rxReady), 32'h1);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        check_status("mid_rst_status", 32'h0000_000A);
        tick();
        rst = 1'b1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
